// File: rtl/psum_stitcher.sv
// Purpose: stitches overlapping 9-lane PE partial-sum chunks into a contiguous 7-lane row stream, plus a 2-lane tail beat per row.
// Latency: a beat accepted at cycle t is on out_*_o at t+1; the tail is loaded once the last body beat drains (earliest t+2).
// Backpressure: psum_ready_o drops while the registered output stage is full and stalled, and while a tail beat is owed.
//
// Ports:
//   clk, rst                 single clock, synchronous active-high reset
//   psum_i / psum_first_i / psum_last_i / psum_valid_i / psum_ready_o
//                            PE beat input (IN_NUM lanes of DW bits, lane i at [i*DW +: DW])
//   out_data_o / out_lanes_o / out_last_o / out_valid_o / out_ready_i
//                            stitched output beat (OUT_NUM lanes, lane j at [j*DW +: DW])
module psum_stitcher #(
   parameter int IW      = 24,
   parameter int FW      = 8,
   parameter int IN_NUM  = 9,
   parameter int OUT_NUM = 7
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [IN_NUM*(IW+FW)-1:0]  psum_i,
   input  logic                      psum_first_i,
   input  logic                      psum_last_i,
   input  logic                      psum_valid_i,
   output logic                      psum_ready_o,
   output logic [OUT_NUM*(IW+FW)-1:0] out_data_o,
   output logic [2:0]                out_lanes_o,
   output logic                      out_last_o,
   output logic                      out_valid_o,
   input  logic                      out_ready_i
);

   localparam int DW = IW + FW;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ROW  = 2'd1,
      S_TAIL = 2'd2
   } state_t;

   state_t                   state, state_nxt;
   logic [DW-1:0]            c0, c1, c0_nxt, c1_nxt;
   logic [OUT_NUM*DW-1:0]    out_data_nxt;
   logic [2:0]               out_lanes_nxt;
   logic                     out_last_nxt;
   logic                     out_valid_nxt;

   logic                     accept;
   logic                     use_carry;
   logic [DW-1:0]            carry0, carry1;

   // Ready depends only on state and the output stage, never on psum_valid_i.
   assign psum_ready_o = (state != S_TAIL) && (!out_valid_o || out_ready_i);
   assign accept       = psum_valid_i && psum_ready_o;

   // The carry only belongs to the current row while a row is open; a first
   // beat (new row, possibly abandoning an old one) or a stray beat in IDLE
   // starts from zero.
   assign use_carry = (state == S_ROW) && !psum_first_i;
   assign carry0    = use_carry ? c0 : '0;
   assign carry1    = use_carry ? c1 : '0;

   always_comb begin
      state_nxt     = state;
      c0_nxt        = c0;
      c1_nxt        = c1;
      out_data_nxt  = out_data_o;
      out_lanes_nxt = out_lanes_o;
      out_last_nxt  = out_last_o;
      out_valid_nxt = out_valid_o;

      // Output beat consumed downstream; may be refilled below in the same cycle.
      if (out_valid_o && out_ready_i) begin
         out_valid_nxt = 1'b0;
      end

      case (state)
         S_IDLE, S_ROW: begin
            if (accept) begin
               for (int j = 0; j < OUT_NUM; j++) begin
                  out_data_nxt[j*DW +: DW] = psum_i[j*DW +: DW];
               end
               // Overlap lanes: plain modulo-2^DW add, values already Q-format aligned.
               out_data_nxt[0*DW +: DW] = carry0 + psum_i[0*DW +: DW];
               out_data_nxt[1*DW +: DW] = carry1 + psum_i[1*DW +: DW];
               out_lanes_nxt = 3'd7;
               out_last_nxt  = 1'b0;
               out_valid_nxt = 1'b1;
               c0_nxt        = psum_i[7*DW +: DW];
               c1_nxt        = psum_i[8*DW +: DW];
               state_nxt     = psum_last_i ? S_TAIL : S_ROW;
            end
         end
         S_TAIL: begin
            if (!out_valid_o || out_ready_i) begin
               if (out_valid_o && out_last_o) begin
                  // Tail beat just went out: row closed.
                  state_nxt = S_IDLE;
               end else begin
                  // Body beat of the last chunk drained: the carry is the tail.
                  out_data_nxt             = '0;
                  out_data_nxt[0*DW +: DW] = c0;
                  out_data_nxt[1*DW +: DW] = c1;
                  out_lanes_nxt            = 3'd2;
                  out_last_nxt             = 1'b1;
                  out_valid_nxt            = 1'b1;
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         c0          <= '0;
         c1          <= '0;
         out_data_o  <= '0;
         out_lanes_o <= '0;
         out_last_o  <= 1'b0;
         out_valid_o <= 1'b0;
      end else begin
         state       <= state_nxt;
         c0          <= c0_nxt;
         c1          <= c1_nxt;
         out_data_o  <= out_data_nxt;
         out_lanes_o <= out_lanes_nxt;
         out_last_o  <= out_last_nxt;
         out_valid_o <= out_valid_nxt;
      end
   end

endmodule

// File: doc/psum_stitcher.md
# psum_stitcher

Consumer-side companion of the 3x3 PE row. Each PE beat delivers 9 Q24.8 partial sums for a 7-pixel input chunk, and adjacent chunks overlap by 2 output positions. This block accepts PE beats over a valid/ready handshake and adds the 2-lane overlap carried from the previous chunk. It then emits a contiguous stream of full-convolution row results, 7 lanes per beat, plus a 2-lane tail beat at end of row, to the output/accumulation buffer.

## Interface
Parameters:
- IW, 24, integer bits of Q format
- FW, 8, fraction bits; word width DW = IW+FW
- IN_NUM, 9, partial sums per PE beat; fixed at 9, other values unsupported
- OUT_NUM, 7, lanes per output beat; fixed at 7

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset; synchronous, active-high
- psum_i  in  IN_NUM*DW  partial sums; lane i at bits [i*DW +: DW]
- psum_first_i  in  1  beat is the first chunk of a row; qualified by psum_valid_i
- psum_last_i  in  1  beat is the last chunk of a row; may coincide with psum_first_i
- psum_valid_i  in  1  beat valid
- psum_ready_o  out  1  block accepts the beat this cycle
- out_data_o  out  OUT_NUM*DW  stitched results; lane j at bits [j*DW +: DW]
- out_lanes_o  out  3  count of valid lanes: 7 for a body beat, 2 for a tail beat
- out_last_o  out  1  final beat of the row (the tail beat)
- out_valid_o  out  1  output beat valid
- out_ready_i  in  1  downstream accepts

## Operation
- Carry registers c0 and c1 (DW each) hold lanes 7 and 8 of the previous chunk of the current row.
- Body beat on acceptance of chunk p:
  - lane0 = c0+p0, lane1 = c1+p1, lanes 2..6 = p2..p6.
  - Then c0 <= p7, c1 <= p8.
  - If psum_first_i=1, the carry is treated as zero for this beat.
- Arithmetic: plain two's-complement DW-bit add, wraps modulo 2^DW. No saturation and no rescale, because the values are already Q24.8.
- Tail beat after the body beat of a last chunk:
  - lanes 0,1 = p7,p8 of that chunk; lanes 2..6 = 0.
  - out_lanes_o=2, out_last_o=1.
- Row of N chunks therefore yields N body beats + 1 tail beat = 7N+2 results.
- FSM states:
  - IDLE: no row open, carry invalid.
  - ROW: carry valid.
  - TAIL: tail beat owed.
- FSM transitions on accepted input:
  - first & !last: go to ROW.
  - !first & !last, from ROW: stay in ROW.
  - last (with or without first): go to TAIL.
  - !first in IDLE: protocol error; the carry is treated as zero, the row opens in ROW, and a body beat is still emitted.
  - first in ROW: the open row is abandoned, its carry is discarded with no tail, and a new row starts.
- TAIL: psum_ready_o=0. When the body beat has drained and the tail beat is accepted downstream, go to IDLE.
- Output register: out_data_o, out_lanes_o, out_last_o and out_valid_o are registered, and hold stable while out_valid_o && !out_ready_i.

## Timing
- Reset values: out_valid_o=0, out_last_o=0, out_lanes_o=0, out_data_o=0, c0=c1=0, state=IDLE. psum_ready_o=1 the cycle after reset deasserts.
- psum_ready_o = (state!=TAIL) && (!out_valid_o || out_ready_i). It is combinational from state and the output stage, and has no combinational path from psum_valid_i.
- Latency: a beat accepted at cycle t appears on out_*_o at cycle t+1.
- Throughput: 1 beat/cycle under no backpressure. A row of N chunks takes N+1 output cycles, and the next row's first chunk is accepted in the tail cycle+1 at the earliest.
- Tail: loaded into the output stage in the cycle the body beat of the last chunk is accepted downstream (earliest t+2).
- Backpressure: with out_ready_i=0, no input is accepted once the output stage is full, and the carry is unchanged.
- rst mid-row: all state is cleared, any pending tail is dropped, out_valid_o=0 next cycle, and no partial beat is emitted.

## Test plan
- Single-chunk row (first=last=1), p_i = i+1 in Q24.8, i.e. 0x100*(i+1):
  - beat 1: lanes = 0x100..0x700, lanes=7, last=0.
  - beat 2: lanes0,1 = 0x800, 0x900; lanes 2..6 = 0; lanes=2, last=1.
- Two-chunk row, both chunks p_i = 0x100:
  - beat 1: all lanes 0x100.
  - beat 2: lane0 = lane1 = 0x200, others 0x100.
  - tail: 0x100, 0x100.
- Wrap check: carry 0x7FFFFFFF plus p0 = 0x00000001 gives lane0 = 0x80000000. Negative case: carry 0xFFFFFF00 (-1.0) plus p1 = 0x100 gives lane1 = 0.
- Backpressure: hold out_ready_i=0 for 5 cycles mid-row.
  - psum_ready_o stays 0 while the output stage is full.
  - out_data_o is stable; no beat is lost or duplicated.
  - The sequence matches the golden model after release.
- Protocol errors:
  - first asserted mid-row: no tail is emitted for the old row, and the new row's lanes 0,1 exclude the old carry.
  - !first beat in IDLE: lanes 0,1 equal p0,p1.
- Reset asserted in TAIL with out_ready_i=0: out_valid_o=0 next cycle, the tail is never emitted, and the next first chunk is processed with zero carry.
